// File: rtl/drive_pkg.sv
// Purpose: shared types, IR/camera code constants and small decode helpers for the drive arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package drive_pkg;

  // Arbitration states; the encoding is also the externally visible `mode`.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_TRACK  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    DIR_STOP  = 2'b00,
    DIR_FWD   = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  // Drive code as carried on tx_state: {spd, dir}.
  typedef struct packed {
    logic [1:0] spd;
    dir_t       dir;
  } drive_code_t;

  localparam logic [7:0] IR_FWD   = 8'h02;
  localparam logic [7:0] IR_LEFT  = 8'h04;
  localparam logic [7:0] IR_RIGHT = 8'h06;
  localparam logic [7:0] IR_STOP  = 8'h05;
  localparam logic [7:0] IR_AUTO  = 8'h0C;

  localparam logic [2:0] CAM_NONE   = 3'd0;
  localparam logic [2:0] CAM_LEFT   = 3'd1;
  localparam logic [2:0] CAM_CENTRE = 3'd2;
  localparam logic [2:0] CAM_RIGHT  = 3'd3;

  // Only meaningful for the three movement codes; callers qualify first.
  function automatic dir_t ir_to_dir(input logic [7:0] code);
    case (code)
      IR_LEFT:  return DIR_LEFT;
      IR_RIGHT: return DIR_RIGHT;
      default:  return DIR_FWD;
    endcase
  endfunction

  function automatic logic cam_is_target(input logic [2:0] cam);
    return (cam == CAM_LEFT) || (cam == CAM_CENTRE) || (cam == CAM_RIGHT);
  endfunction

  // Centre means drive straight at the target.
  function automatic dir_t cam_to_dir(input logic [2:0] cam);
    case (cam)
      CAM_LEFT:  return DIR_LEFT;
      CAM_RIGHT: return DIR_RIGHT;
      default:   return DIR_FWD;
    endcase
  endfunction

endpackage

// File: rtl/drive_tx_sched.sv
// Purpose: decides when the desired drive code is offered to the UART/JSON transmitter.
// Latency: desired change seen in cycle N -> tx_valid in N+1 when the gap has expired.
// Backpressure: tx_state frozen while tx_valid is high; keepalive is deferred, never dropped.
//
// Ports: clk_50/reset (sync, active-high), desired (4-bit drive code), tx_ready in;
//        tx_valid, tx_state out.
module drive_tx_sched
  import drive_pkg::*;
#(
  parameter int MIN_GAP_CYCLES   = 2_500_000,
  parameter int KEEPALIVE_CYCLES = 25_000_000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [3:0] desired,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [3:0] tx_state
);

  localparam int GAP_W = $clog2(MIN_GAP_CYCLES + 1);
  localparam int KA_W  = $clog2(KEEPALIVE_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP_CYCLES);
  localparam logic [KA_W-1:0]  KA_LOAD  = KA_W'(KEEPALIVE_CYCLES);

  logic [3:0]       last_sent;
  logic [GAP_W-1:0] gap_cnt;
  logic [KA_W-1:0]  ka_cnt;
  logic             handshake;
  logic             launch;

  assign handshake = tx_valid & tx_ready;

  // A new offer needs an empty slot and an expired gap; it is triggered either
  // by a changed command or by the keepalive timer having run down.
  assign launch = !tx_valid && (gap_cnt == '0) &&
                  ((desired != last_sent) || (ka_cnt == '0));

  always_ff @(posedge clk_50) begin
    if (reset) begin
      tx_valid  <= 1'b0;
      tx_state  <= 4'h0;
      last_sent <= 4'h0;
      gap_cnt   <= '0;
      ka_cnt    <= KA_LOAD;
    end else if (handshake) begin
      last_sent <= tx_state;
      tx_valid  <= 1'b0;
      gap_cnt   <= GAP_LOAD;
      ka_cnt    <= KA_LOAD;
    end else begin
      if (launch) begin
        tx_valid <= 1'b1;
        tx_state <= desired;
      end
      // Both timers saturate at zero so a pending keepalive stays due.
      if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
      if (ka_cnt != '0)  ka_cnt  <= ka_cnt - KA_W'(1);
    end
  end

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Purpose: arbitrates IR manual, camera tracking and mic speed into one drive code for the transmitter.
// Latency: ir_valid in cycle N -> mode/desired in N+1 -> tx_valid in N+2 (gap permitting).
// Backpressure: pending command is held until tx_ready; later changes collapse to the latest value.
//
// Ports: clk_50/reset (sync, active-high); ir_valid/ir_button, cam_direction/orange_detected,
//        speed, tx_ready in; tx_valid/tx_state (to transmitter), mode, auto_en out.
module drive_cmd_arbiter
  import drive_pkg::*;
#(
  parameter int IR_HOLD_CYCLES   = 50_000_000,
  parameter int CAM_LOST_CYCLES  = 12_500_000,
  parameter int MIN_GAP_CYCLES   = 2_500_000,
  parameter int KEEPALIVE_CYCLES = 25_000_000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       ir_valid,
  input  logic [7:0] ir_button,
  input  logic [2:0] cam_direction,
  input  logic       orange_detected,
  input  logic [1:0] speed,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [3:0] tx_state,
  output logic [1:0] mode,
  output logic       auto_en
);

  localparam int HOLD_W = $clog2(IR_HOLD_CYCLES + 1);
  localparam int LOST_W = $clog2(CAM_LOST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(IR_HOLD_CYCLES);
  localparam logic [LOST_W-1:0] LOST_LOAD = LOST_W'(CAM_LOST_CYCLES);

  arb_state_t        state;
  arb_state_t        state_nxt;
  dir_t              man_dir;
  dir_t              track_dir;
  logic [HOLD_W-1:0] hold_cnt;
  logic [LOST_W-1:0] lost_cnt;
  drive_code_t       desired;

  logic ir_move;
  logic ir_stop;
  logic ir_auto;
  logic cam_hit;

  assign ir_move = ir_valid && ((ir_button == IR_FWD) || (ir_button == IR_LEFT) ||
                                (ir_button == IR_RIGHT));
  assign ir_stop = ir_valid && (ir_button == IR_STOP);
  assign ir_auto = ir_valid && (ir_button == IR_AUTO);
  assign cam_hit = orange_detected && cam_is_target(cam_direction);

  // State register.
  always_ff @(posedge clk_50) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state. IR events are checked first so they win over camera events in
  // the same cycle. Timeouts compare against 1 so the state leaves on the very
  // edge where the counter steps to 0, i.e. exactly N cycles after the reload.
  always_comb begin
    state_nxt = state;
    if (ir_move) begin
      state_nxt = ST_MANUAL;
    end else if (ir_stop || ir_auto) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (auto_en && cam_hit) state_nxt = ST_TRACK;
        ST_MANUAL: if (hold_cnt <= HOLD_W'(1)) state_nxt = ST_IDLE;
        ST_TRACK:  if (!cam_hit && (lost_cnt <= LOST_W'(1))) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs of the FSM: visible mode and the command it wants on the wire.
  always_comb begin
    mode    = state;
    desired = '{spd: 2'b00, dir: DIR_STOP};
    case (state)
      ST_MANUAL: desired = '{spd: speed, dir: man_dir};
      ST_TRACK:  desired = '{spd: speed, dir: track_dir};
      default:   desired = '{spd: 2'b00, dir: DIR_STOP};
    endcase
  end

  // Latched directions and lifetime counters. The lost counter reloads on any
  // valid sighting; entry into TRACK always coincides with one, so it starts full.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      auto_en   <= 1'b1;
      man_dir   <= DIR_STOP;
      track_dir <= DIR_STOP;
      hold_cnt  <= '0;
      lost_cnt  <= '0;
    end else begin
      if (ir_stop)      auto_en <= 1'b0;
      else if (ir_auto) auto_en <= 1'b1;

      if (ir_move) begin
        man_dir  <= ir_to_dir(ir_button);
        hold_cnt <= HOLD_LOAD;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end

      if (cam_hit) begin
        track_dir <= cam_to_dir(cam_direction);
        lost_cnt  <= LOST_LOAD;
      end else if (lost_cnt != '0) begin
        lost_cnt <= lost_cnt - LOST_W'(1);
      end
    end
  end

  drive_tx_sched #(
    .MIN_GAP_CYCLES  (MIN_GAP_CYCLES),
    .KEEPALIVE_CYCLES(KEEPALIVE_CYCLES)
  ) u_tx_sched (
    .clk_50  (clk_50),
    .reset   (reset),
    .desired (desired),
    .tx_ready(tx_ready),
    .tx_valid(tx_valid),
    .tx_state(tx_state)
  );

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Purpose: self-checking bench for drive_cmd_arbiter, directed scenarios plus a randomized run against a reference model.
// Latency: n/a.
// Backpressure: tx_ready driven by the bench, including long stalls.
module tb_drive_cmd_arbiter;

  localparam int IR_HOLD   = 100;
  localparam int CAM_LOST  = 50;
  localparam int MIN_GAP   = 20;
  localparam int KEEPALIVE = 500;

  localparam logic [7:0] B_FWD   = 8'h02;
  localparam logic [7:0] B_LEFT  = 8'h04;
  localparam logic [7:0] B_RIGHT = 8'h06;
  localparam logic [7:0] B_STOP  = 8'h05;
  localparam logic [7:0] B_AUTO  = 8'h0C;

  logic       clk_50 = 1'b0;
  logic       reset;
  logic       ir_valid;
  logic [7:0] ir_button;
  logic [2:0] cam_direction;
  logic       orange_detected;
  logic [1:0] speed;
  logic       tx_ready;
  logic       tx_valid;
  logic [3:0] tx_state;
  logic [1:0] mode;
  logic       auto_en;

  drive_cmd_arbiter #(
    .IR_HOLD_CYCLES  (IR_HOLD),
    .CAM_LOST_CYCLES (CAM_LOST),
    .MIN_GAP_CYCLES  (MIN_GAP),
    .KEEPALIVE_CYCLES(KEEPALIVE)
  ) dut (
    .clk_50         (clk_50),
    .reset          (reset),
    .ir_valid       (ir_valid),
    .ir_button      (ir_button),
    .cam_direction  (cam_direction),
    .orange_detected(orange_detected),
    .speed          (speed),
    .tx_ready       (tx_ready),
    .tx_valid       (tx_valid),
    .tx_state       (tx_state),
    .mode           (mode),
    .auto_en        (auto_en)
  );

  always #5 clk_50 = ~clk_50;

  int total = 0;
  int bad   = 0;

  // Reference model: mode/auto flags plus the cycle index of the most recent
  // event of each kind; timeouts are "elapsed cycles since that event".
  int         e = 0;
  logic [1:0] m_mode;
  logic       m_auto;
  logic [1:0] m_mdir;
  logic [1:0] m_tdir;
  logic       m_valid;
  logic [3:0] m_tx;
  logic [3:0] m_last;
  int         ir_ref, det_ref, gap_ref, ka_ref;

  // Transfers seen on the DUT interface (value and cycle index).
  logic [3:0] hs_q[$];
  int         hs_t[$];

  function automatic logic [1:0] tb_cam_dir(input logic [2:0] c);
    case (c)
      3'd1:    return 2'b10;
      3'd2:    return 2'b01;
      3'd3:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] tb_ir_dir(input logic [7:0] b);
    if (b == B_LEFT)  return 2'b10;
    if (b == B_RIGHT) return 2'b11;
    return 2'b01;
  endfunction

  task automatic model_step();
    logic [3:0] d;
    logic       hit;
    e++;
    if (reset) begin
      m_mode = 2'd0; m_auto = 1'b1; m_mdir = 2'b00; m_tdir = 2'b00;
      m_valid = 1'b0; m_tx = 4'h0; m_last = 4'h0;
      gap_ref = -1000000; ka_ref = e; ir_ref = e; det_ref = e;
      return;
    end
    if (m_mode == 2'd1)      d = {speed, m_mdir};
    else if (m_mode == 2'd2) d = {speed, m_tdir};
    else                     d = 4'h0;
    if (m_valid && tx_ready) begin
      m_last = m_tx; m_valid = 1'b0; gap_ref = e; ka_ref = e;
    end else if (!m_valid && (e - gap_ref > MIN_GAP) &&
                 ((d != m_last) || (e - ka_ref > KEEPALIVE))) begin
      m_valid = 1'b1; m_tx = d;
    end
    hit = orange_detected && (cam_direction inside {3'd1, 3'd2, 3'd3});
    if (ir_valid && (ir_button inside {B_FWD, B_LEFT, B_RIGHT})) begin
      m_mode = 2'd1; m_mdir = tb_ir_dir(ir_button); ir_ref = e;
    end else if (ir_valid && ir_button == B_STOP) begin
      m_mode = 2'd0; m_auto = 1'b0;
    end else if (ir_valid && ir_button == B_AUTO) begin
      m_mode = 2'd0; m_auto = 1'b1;
    end else begin
      case (m_mode)
        2'd0: if (m_auto && hit) begin m_mode = 2'd2; m_tdir = tb_cam_dir(cam_direction); det_ref = e; end
        2'd1: if (e - ir_ref >= IR_HOLD) m_mode = 2'd0;
        2'd2: if (hit) begin m_tdir = tb_cam_dir(cam_direction); det_ref = e; end
              else if (e - det_ref >= CAM_LOST) m_mode = 2'd0;
        default: m_mode = 2'd0;
      endcase
    end
  endtask

  // One clock: note a transfer about to happen, advance DUT and model, settle.
  task automatic step();
    if (!reset && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      hs_q.push_back(tx_state);
      hs_t.push_back(e);
    end
    @(posedge clk_50);
    model_step();
    #1;
  endtask

  task automatic pulse_ir(input logic [7:0] b);
    ir_valid = 1'b1; ir_button = b;
    step();
    ir_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; ir_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    hs_q.delete(); hs_t.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; ir_valid = 1'b0; ir_button = 8'h00; cam_direction = 3'd0;
    orange_detected = 1'b0; speed = 2'd0; tx_ready = 1'b0;
    step(); step();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    total++; if (tx_state !== 4'h0) begin bad++; $display("FAIL reset_tx_state got=%h want=0", tx_state); end
    total++; if (mode !== 2'd0)     begin bad++; $display("FAIL reset_mode got=%0d want=0", mode); end
    total++; if (auto_en !== 1'b1)  begin bad++; $display("FAIL reset_auto_en got=%b want=1", auto_en); end
    reset = 1'b0;
    step(); step();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL idle_no_send got=%b want=0", tx_valid); end
  endtask

  task automatic test_manual();
    int n;
    do_reset();
    speed = 2'd2; tx_ready = 1'b1;
    pulse_ir(B_FWD);
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL manual_mode got=%0d want=1", mode); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL manual_early_valid got=%b want=0", tx_valid); end
    step();
    total++;
    if (tx_valid !== 1'b1 || tx_state !== 4'b1001) begin
      bad++; $display("FAIL manual_send got=%b/%b want=1/1001", tx_valid, tx_state);
    end
    n = 2;
    while (mode === 2'd1 && n < 300) begin
      step();
      if (mode === 2'd1) n++;
    end
    total++; if (n != IR_HOLD) begin bad++; $display("FAIL manual_hold_cycles got=%0d want=%0d", n, IR_HOLD); end
    step(); step();
    total++;
    if (hs_q.size() != 2 || hs_q[0] !== 4'b1001 || hs_q[1] !== 4'h0) begin
      bad++; $display("FAIL manual_sequence got_count=%0d want=2 (1001 then 0000)", hs_q.size());
    end
  endtask

  task automatic test_track();
    int n;
    do_reset();
    speed = 2'd1; tx_ready = 1'b1; orange_detected = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      cam_direction = 3'(s);
      repeat (30) step();
      total++; if (mode !== 2'd2) begin bad++; $display("FAIL track_mode seg=%0d got=%0d want=2", s, mode); end
    end
    orange_detected = 1'b0; cam_direction = 3'd0;
    n = 0;
    while (mode === 2'd2 && n < 200) begin
      step(); n++;
    end
    total++; if (n != CAM_LOST) begin bad++; $display("FAIL track_lost_cycles got=%0d want=%0d", n, CAM_LOST); end
    repeat (3) step();
    total++;
    if (hs_q.size() != 4 || hs_q[0] !== 4'b0110 || hs_q[1] !== 4'b0101 ||
        hs_q[2] !== 4'b0111 || hs_q[3] !== 4'b0000) begin
      bad++; $display("FAIL track_sequence got_count=%0d want=4 (0110 0101 0111 0000)", hs_q.size());
    end
    for (int i = 1; i < hs_t.size(); i++) begin
      total++;
      if (hs_t[i] - hs_t[i-1] < MIN_GAP) begin
        bad++; $display("FAIL track_gap idx=%0d got=%0d want>=%0d", i, hs_t[i] - hs_t[i-1], MIN_GAP);
      end
    end
  endtask

  task automatic test_priority();
    logic ok;
    orange_detected = 1'b0;
    do_reset();
    speed = 2'd3; tx_ready = 1'b1; orange_detected = 1'b1; cam_direction = 3'd2;
    pulse_ir(B_LEFT);
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL prio_ir_wins got=%0d want=1", mode); end
    step();
    total++;
    if (tx_valid !== 1'b1 || tx_state[1:0] !== 2'b10) begin
      bad++; $display("FAIL prio_left_code got=%b/%b want=1/xx10", tx_valid, tx_state);
    end
    pulse_ir(B_STOP);
    total++;
    if (mode !== 2'd0 || auto_en !== 1'b0) begin
      bad++; $display("FAIL prio_stop got=%0d/%b want=0/0", mode, auto_en);
    end
    ok = 1'b1;
    repeat (20) begin
      step();
      if (mode !== 2'd0) ok = 1'b0;
    end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL prio_no_track_when_disabled got=left_idle want=stay_idle"); end
    pulse_ir(B_AUTO);
    total++;
    if (mode !== 2'd0 || auto_en !== 1'b1) begin
      bad++; $display("FAIL prio_auto got=%0d/%b want=0/1", mode, auto_en);
    end
    step();
    total++; if (mode !== 2'd2) begin bad++; $display("FAIL prio_track_after_auto got=%0d want=2", mode); end
    pulse_ir(8'h33);
    total++; if (mode !== 2'd2) begin bad++; $display("FAIL prio_unknown_code got=%0d want=2", mode); end
  endtask

  task automatic test_back_to_back();
    logic ok;
    logic mid_seen;
    orange_detected = 1'b0;
    do_reset();
    speed = 2'd0; tx_ready = 1'b0;
    pulse_ir(B_FWD);
    step();
    ok = 1'b1;
    for (int t = 0; t < 200; t++) begin
      ir_valid  = (t == 60) || (t == 120) || (t == 180);
      ir_button = (t == 60) ? B_LEFT : B_RIGHT;
      step();
      if (tx_valid !== 1'b1 || tx_state !== 4'b0001) ok = 1'b0;
    end
    ir_valid = 1'b0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_frozen got=%b/%b want=1/0001", tx_valid, tx_state); end
    hs_q.delete(); hs_t.delete();
    tx_ready = 1'b1;
    repeat (40) step();
    total++;
    if (hs_q.size() != 2 || hs_q[0] !== 4'b0001 || hs_q[1] !== 4'b0011) begin
      bad++; $display("FAIL stall_sequence got_count=%0d want=2 (0001 then 0011)", hs_q.size());
    end
    mid_seen = 1'b0;
    foreach (hs_q[i]) if (hs_q[i] === 4'b0010) mid_seen = 1'b1;
    total++; if (mid_seen !== 1'b0) begin bad++; $display("FAIL stall_middle_sent got=1 want=0"); end
    if (hs_t.size() >= 2) begin
      total++;
      if (hs_t[1] - hs_t[0] < MIN_GAP || hs_t[1] - hs_t[0] > MIN_GAP + 2) begin
        bad++; $display("FAIL stall_gap got=%0d want=%0d..%0d", hs_t[1] - hs_t[0], MIN_GAP, MIN_GAP + 2);
      end
    end
  endtask

  task automatic test_keepalive();
    int n;
    do_reset();
    speed = 2'd3; tx_ready = 1'b1;
    for (int t = 0; t < 1200; t++) begin
      ir_valid = (t % 90 == 0); ir_button = B_FWD;
      step();
    end
    ir_valid = 1'b0;
    total++; if (hs_q.size() != 3) begin bad++; $display("FAIL ka_count got=%0d want=3", hs_q.size()); end
    foreach (hs_q[i]) begin
      total++; if (hs_q[i] !== 4'b1101) begin bad++; $display("FAIL ka_value idx=%0d got=%b want=1101", i, hs_q[i]); end
    end
    for (int i = 1; i < hs_t.size(); i++) begin
      total++;
      if (hs_t[i] - hs_t[i-1] < KEEPALIVE || hs_t[i] - hs_t[i-1] > KEEPALIVE + 2) begin
        bad++; $display("FAIL ka_spacing idx=%0d got=%0d want=%0d..%0d", i, hs_t[i] - hs_t[i-1], KEEPALIVE, KEEPALIVE + 2);
      end
    end
    tx_ready = 1'b0;
    pulse_ir(B_LEFT);
    n = 0;
    while (tx_valid !== 1'b1 && n < 50) begin
      step(); n++;
    end
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL ka_pending_timeout got=%b want=1", tx_valid); end
    reset = 1'b1;
    step();
    total++;
    if (tx_valid !== 1'b0 || tx_state !== 4'h0 || mode !== 2'd0 || auto_en !== 1'b1) begin
      bad++; $display("FAIL midreset got=%b/%h/%0d/%b want=0/0/0/1", tx_valid, tx_state, mode, auto_en);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    int run;
    orange_detected = 1'b0;
    do_reset();
    run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        orange_detected = 1'($urandom_range(0, 1));
        cam_direction   = 3'($urandom_range(0, 7));
        run = $urandom_range(1, 70);
      end
      run--;
      ir_valid = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 5))
        0: ir_button = B_FWD;
        1: ir_button = B_LEFT;
        2: ir_button = B_RIGHT;
        3: ir_button = B_STOP;
        4: ir_button = B_AUTO;
        default: ir_button = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 199) == 0) speed = 2'($urandom_range(0, 3));
      tx_ready = ($urandom_range(0, 9) < 7);
      reset    = ($urandom_range(0, 999) == 0);
      step();
      total++;
      if (tx_valid !== m_valid || tx_state !== m_tx || mode !== m_mode || auto_en !== m_auto) begin
        bad++;
        $display("FAIL random cyc=%0d got v=%b s=%b m=%0d a=%b want v=%b s=%b m=%0d a=%b",
                 c, tx_valid, tx_state, mode, auto_en, m_valid, m_tx, m_mode, m_auto);
      end
    end
    reset = 1'b0; ir_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_track();
    test_priority();
    test_back_to_back();
    test_keepalive();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
